// File: rtl/clock24_display_mux.sv
// clock24_display_mux
// Drives a 4-digit common-anode 7-segment display from the 24-hour clock
// and its set stage. Digits are scanned one at a time; the field being edited
// blinks; inputs are snapshotted once per frame so a carry mid-scan cannot
// tear the displayed value.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   set_state    0=run, 1=edit hours, 2=edit minutes, 3=confirm
//   show_seconds run mode only: show MM.SS instead of HH.MM
//   hours, minutes, seconds   running time, binary
//   in_hours, in_minutes      values being edited, binary
//   an           digit enables, active-low, an[0]=rightmost
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point (colon), active-low
module clock24_display_mux #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] set_state,
  input  logic       show_seconds,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [4:0] in_hours,
  input  logic [5:0] in_minutes,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Decimal tens digit of a 0..63 value.
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    tens_of = 4'(v / 6'd10);
  endfunction

  // Decimal ones digit of a 0..63 value.
  function automatic logic [3:0] ones_of(input logic [5:0] v);
    ones_of = 4'(v % 6'd10);
  endfunction

  // BCD digit to active-low gfedcba pattern; non-decimal codes go dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b1000000;
      4'd1:    seg_code = 7'b1111001;
      4'd2:    seg_code = 7'b0100100;
      4'd3:    seg_code = 7'b0110000;
      4'd4:    seg_code = 7'b0011001;
      4'd5:    seg_code = 7'b0010010;
      4'd6:    seg_code = 7'b0000010;
      4'd7:    seg_code = 7'b1111000;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0010000;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Scan / blink state
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         digit_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic               blink_on_r;
  logic               load_pending_r;

  // Snapshot registers
  logic [1:0] snap_state_r;
  logic       snap_show_sec_r;
  logic [4:0] snap_hours_r;
  logic [5:0] snap_minutes_r;
  logic [5:0] snap_seconds_r;
  logic [4:0] snap_in_hours_r;
  logic [5:0] snap_in_minutes_r;

  // Registered outputs
  logic [3:0] an_r;
  logic [6:0] seg_r;
  logic       dp_r;

  logic       scan_wrap_s;
  logic       frame_wrap_s;
  logic       capture_s;

  // Effective snapshot: on the very first cycle after reset the snapshot
  // registers still hold zero, so the live inputs are used directly.
  logic [1:0] eff_state_s;
  logic       eff_show_sec_s;
  logic [4:0] eff_hours_s;
  logic [5:0] eff_minutes_s;
  logic [5:0] eff_seconds_s;
  logic [4:0] eff_in_hours_s;
  logic [5:0] eff_in_minutes_s;

  logic [5:0] left_s;
  logic [5:0] right_s;
  logic       left_is_hours_s;
  logic       left_bad_s;
  logic       right_bad_s;
  logic [3:0] bcd_s;
  logic       bad_s;
  logic       blank_s;
  logic [3:0] an_next_s;
  logic [6:0] seg_next_s;
  logic       dp_next_s;

  assign scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
  assign frame_wrap_s = scan_wrap_s && (digit_r == 2'd3);
  assign capture_s    = load_pending_r || frame_wrap_s;

  assign eff_state_s      = load_pending_r ? set_state    : snap_state_r;
  assign eff_show_sec_s   = load_pending_r ? show_seconds : snap_show_sec_r;
  assign eff_hours_s      = load_pending_r ? hours        : snap_hours_r;
  assign eff_minutes_s    = load_pending_r ? minutes      : snap_minutes_r;
  assign eff_seconds_s    = load_pending_r ? seconds      : snap_seconds_r;
  assign eff_in_hours_s   = load_pending_r ? in_hours     : snap_in_hours_r;
  assign eff_in_minutes_s = load_pending_r ? in_minutes   : snap_in_minutes_r;

  // Digit dwell counter and digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= '0;
      digit_r    <= 2'd0;
    end else if (scan_wrap_s) begin
      scan_cnt_r <= '0;
      digit_r    <= digit_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      digit_r    <= digit_r;
    end
  end

  // Frame counter and blink phase; blink is held on outside edit modes
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      if (frame_wrap_s) begin
        frame_cnt_r <= (frame_cnt_r == FRAME_LAST) ? '0 : frame_cnt_r + FRAME_W'(1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if ((eff_state_s == 2'd0) || (eff_state_s == 2'd3)) begin
        blink_on_r <= 1'b1;
      end else if (frame_wrap_s && (frame_cnt_r == FRAME_LAST)) begin
        blink_on_r <= ~blink_on_r;
      end else begin
        blink_on_r <= blink_on_r;
      end
    end
  end

  // Per-frame input snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      load_pending_r    <= 1'b1;
      snap_state_r      <= 2'd0;
      snap_show_sec_r   <= 1'b0;
      snap_hours_r      <= 5'd0;
      snap_minutes_r    <= 6'd0;
      snap_seconds_r    <= 6'd0;
      snap_in_hours_r   <= 5'd0;
      snap_in_minutes_r <= 6'd0;
    end else if (capture_s) begin
      load_pending_r    <= 1'b0;
      snap_state_r      <= set_state;
      snap_show_sec_r   <= show_seconds;
      snap_hours_r      <= hours;
      snap_minutes_r    <= minutes;
      snap_seconds_r    <= seconds;
      snap_in_hours_r   <= in_hours;
      snap_in_minutes_r <= in_minutes;
    end else begin
      load_pending_r    <= load_pending_r;
      snap_state_r      <= snap_state_r;
      snap_show_sec_r   <= snap_show_sec_r;
      snap_hours_r      <= snap_hours_r;
      snap_minutes_r    <= snap_minutes_r;
      snap_seconds_r    <= snap_seconds_r;
      snap_in_hours_r   <= snap_in_hours_r;
      snap_in_minutes_r <= snap_in_minutes_r;
    end
  end

  // Select the left/right value pair and flag out-of-range values
  always_comb begin
    left_s          = {1'b0, eff_hours_s};
    right_s         = eff_minutes_s;
    left_is_hours_s = 1'b1;
    case (eff_state_s)
      2'd0: begin
        if (eff_show_sec_s) begin
          left_s          = eff_minutes_s;
          right_s         = eff_seconds_s;
          left_is_hours_s = 1'b0;
        end else begin
          left_s          = {1'b0, eff_hours_s};
          right_s         = eff_minutes_s;
          left_is_hours_s = 1'b1;
        end
      end
      default: begin
        left_s          = {1'b0, eff_in_hours_s};
        right_s         = eff_in_minutes_s;
        left_is_hours_s = 1'b1;
      end
    endcase
    if (left_is_hours_s) begin
      left_bad_s = (left_s > 6'd23);
    end else begin
      left_bad_s = (left_s > 6'd59);
    end
    right_bad_s = (right_s > 6'd59);
  end

  // Per-digit decode, blanking and decimal point
  always_comb begin
    bcd_s = 4'd0;
    bad_s = 1'b0;
    case (digit_r)
      2'd3: begin
        bcd_s = tens_of(left_s);
        bad_s = left_bad_s;
      end
      2'd2: begin
        bcd_s = ones_of(left_s);
        bad_s = left_bad_s;
      end
      2'd1: begin
        bcd_s = tens_of(right_s);
        bad_s = right_bad_s;
      end
      default: begin
        bcd_s = ones_of(right_s);
        bad_s = right_bad_s;
      end
    endcase

    // digit_r[1] set means one of the left (hours) digits
    blank_s = !blink_on_r &&
              (((eff_state_s == 2'd1) &&  digit_r[1]) ||
               ((eff_state_s == 2'd2) && !digit_r[1]));

    if (blank_s) begin
      seg_next_s = SEG_BLANK;
    end else if (bad_s) begin
      seg_next_s = SEG_DASH;
    end else begin
      seg_next_s = seg_code(bcd_s);
    end

    an_next_s = ~(4'b0001 << digit_r);

    // Colon blinks with seconds in run mode, steady in set modes
    if (digit_r == 2'd2) begin
      if (eff_state_s == 2'd0) begin
        dp_next_s = eff_seconds_s[0];
      end else begin
        dp_next_s = 1'b0;
      end
    end else begin
      dp_next_s = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= dp_next_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
